// File: rtl/vec_pkg.sv
// Shared types for the vector-load collector: lane/vector shapes at default size,
// collector FSM encoding and a helper giving the first lane written for a given order.
package vec_pkg;

   localparam int VEC_WORD_W = 16;
   localparam int VEC_LANES  = 16;
   localparam int VEC_TAG_W  = 5;
   localparam int LANE_IDX_W = $clog2(VEC_LANES);

   typedef logic [VEC_WORD_W-1:0] word_t;
   typedef word_t [VEC_LANES-1:0] vec_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      COMMIT  = 2'd2
   } coll_state_t;

   // Lane that receives the first beat: top lane when filling downward, else lane 0.
   function automatic int first_lane(input int lanes, input bit descending);
      return descending ? (lanes - 1) : 0;
   endfunction

endpackage

// File: rtl/lane_index_counter.sv
// Loadable up/down lane index counter; last_o flags the terminal lane for the chosen direction.
module lane_index_counter
   import vec_pkg::*;
#(
   parameter int LANES = 16,
   parameter int W     = $clog2(LANES)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         en_i,
   input  logic         dir_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] start_val;
   logic [W-1:0] term_val;

   always_comb begin
      start_val = W'(first_lane(LANES, dir_i));
      term_val  = dir_i ? '0 : W'(LANES - 1);
      cnt_d     = cnt_q;
      if (load_i) begin
         cnt_d = start_val;
      end else if (en_i) begin
         cnt_d = dir_i ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == term_val);

endmodule

// File: rtl/vec_load_collector.sv
// Collects LANES memory words into a shadow vector and publishes it, with its
// destination tag, atomically on vec_out_o/tag_out_o together with a done pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; words ignored
//   COLLECT | accepting words into the shadow buffer, one lane per beat
//   COMMIT  | new vector/tag visible, done high for this single cycle
module vec_load_collector
   import vec_pkg::*;
#(
   parameter int WORD_W     = 16,
   parameter int LANES      = 16,
   parameter int TAG_W      = 5,
   parameter bit DESCENDING = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [TAG_W-1:0]        tag_in_i,
   input  logic                    abort_i,
   input  logic                    word_valid_i,
   input  logic [WORD_W-1:0]       word_in_i,
   output logic                    word_ready_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [TAG_W-1:0]        tag_out_o,
   output logic [LANES*WORD_W-1:0] vec_out_o
);

   localparam int IDX_W = $clog2(LANES);

   typedef logic [LANES-1:0][WORD_W-1:0] lanes_t;

   coll_state_t      state_q, state_d;
   lanes_t           shadow_q, shadow_d;
   lanes_t           vec_q, vec_d;
   logic [TAG_W-1:0] tag_pend_q, tag_pend_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             done_q, done_d;

   logic [IDX_W-1:0] cnt;
   logic             cnt_last;
   logic             cnt_load;
   logic             beat;
   logic             commit;

   lane_index_counter #(
      .LANES (LANES),
      .W     (IDX_W)
   ) u_lane_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (cnt_load),
      .en_i   (beat),
      .dir_i  (DESCENDING),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      vec_d      = vec_q;
      tag_pend_d = tag_pend_q;
      tag_d      = tag_q;
      done_d     = 1'b0;

      // An abort in the same cycle as a word discards that word.
      beat     = (state_q == COLLECT) && word_valid_i && !abort_i;
      commit   = beat && cnt_last;
      cnt_load = (state_q == IDLE) && start_i;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = COLLECT;
               tag_pend_d = tag_in_i;
            end
         end
         COLLECT: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (commit) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (beat) begin
         shadow_d[cnt] = word_in_i;
      end

      // The final beat is merged straight into the published vector.
      if (commit) begin
         vec_d  = shadow_d;
         tag_d  = tag_pend_q;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         vec_q      <= '0;
         tag_pend_q <= '0;
         tag_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         vec_q      <= vec_d;
         tag_pend_q <= tag_pend_d;
         tag_q      <= tag_d;
         done_q     <= done_d;
      end
   end

   assign word_ready_o = (state_q == COLLECT);
   assign busy_o       = (state_q == COLLECT);
   assign done_o       = done_q;
   assign tag_out_o    = tag_q;
   assign vec_out_o    = vec_q;

endmodule

// File: tb/tb_vec_load_collector.sv
// Directed bench for the vector-load collector: default 16x16 descending instance
// plus a 4x8 ascending instance.
module tb_vec_load_collector;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: defaults (16 lanes x 16 bits, descending)
   logic         start_a, abort_a, valid_a;
   logic [4:0]   tag_in_a;
   logic [15:0]  word_a;
   logic         ready_a, busy_a, done_a;
   logic [4:0]   tag_a;
   logic [255:0] vec_a;

   // Instance B: 4 lanes x 8 bits, ascending
   logic         start_b, abort_b, valid_b;
   logic [4:0]   tag_in_b;
   logic [7:0]   word_b;
   logic         ready_b, busy_b, done_b;
   logic [4:0]   tag_b;
   logic [31:0]  vec_b;

   int n_checks = 0;
   int n_err    = 0;
   int done_b_cnt = 0;

   localparam logic [255:0] VEC_T2 =
      256'h0100010101020103010401050106010701080109010A010B010C010D010E010F;
   localparam logic [255:0] VEC_T5 =
      256'h2000200120022003200420052006200720082009200A200B200C200D200E200F;

   vec_load_collector u_dut_a (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start_a),
      .tag_in_i     (tag_in_a),
      .abort_i      (abort_a),
      .word_valid_i (valid_a),
      .word_in_i    (word_a),
      .word_ready_o (ready_a),
      .busy_o       (busy_a),
      .done_o       (done_a),
      .tag_out_o    (tag_a),
      .vec_out_o    (vec_a)
   );

   vec_load_collector #(
      .WORD_W     (8),
      .LANES      (4),
      .TAG_W      (5),
      .DESCENDING (1'b0)
   ) u_dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start_b),
      .tag_in_i     (tag_in_b),
      .abort_i      (abort_b),
      .word_valid_i (valid_b),
      .word_in_i    (word_b),
      .word_ready_o (ready_b),
      .busy_o       (busy_b),
      .done_o       (done_b),
      .tag_out_o    (tag_b),
      .vec_out_o    (vec_b)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (done_b) done_b_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 0; abort_a = 0; valid_a = 0; tag_in_a = '0; word_a = '0;
      start_b = 0; abort_b = 0; valid_b = 0; tag_in_b = '0; word_b = '0;
      #12;
      chk("rst_vec", vec_a, '0);
      chk("rst_tag", tag_a, '0);
      chk("rst_ready", ready_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      rst_n = 1'b1;
      tick();

      // 1: reset mid-collection after 7 beats
      start_a = 1; tag_in_a = 5'd7;
      tick();
      start_a = 0;
      chk("t1_ready_collect", ready_a, 1);
      chk("t1_busy_collect", busy_a, 1);
      for (int k = 0; k < 7; k++) begin
         valid_a = 1; word_a = 16'hA000 + 16'(k);
         tick();
      end
      valid_a = 0;
      rst_n = 1'b0;
      #1;
      chk("t1_rst_busy", busy_a, 0);
      chk("t1_rst_ready", ready_a, 0);
      chk("t1_rst_done", done_a, 0);
      chk("t1_rst_vec", vec_a, '0);
      chk("t1_rst_tag", tag_a, '0);
      #2;
      rst_n = 1'b1;
      valid_a = 1; word_a = 16'h5555;
      tick();
      tick();
      chk("t1_ready_after_rst", ready_a, 0);
      chk("t1_busy_after_rst", busy_a, 0);
      valid_a = 0;

      // 2: default parameters, 16 back-to-back beats
      start_a = 1; tag_in_a = 5'd9;
      tick();
      start_a = 0;
      for (int k = 0; k < 16; k++) begin
         valid_a = 1; word_a = 16'h0100 + 16'(k);
         chk("t2_no_early_done", done_a, 0);
         tick();
      end
      valid_a = 0;
      chk("t2_done", done_a, 1);
      chk("t2_tag", tag_a, 5'd9);
      chk("t2_vec", vec_a, VEC_T2);
      chk("t2_busy_commit", busy_a, 0);
      chk("t2_ready_commit", ready_a, 0);
      tick();
      chk("t2_done_pulse", done_a, 0);
      chk("t2_vec_stable", vec_a, VEC_T2);

      // 4: abort after 10 beats
      start_a = 1; tag_in_a = 5'd12;
      tick();
      start_a = 0;
      for (int k = 0; k < 10; k++) begin
         valid_a = 1; word_a = 16'hEE00 + 16'(k);
         tick();
      end
      valid_a = 0; abort_a = 1;
      tick();
      abort_a = 0;
      chk("t4_busy", busy_a, 0);
      chk("t4_done", done_a, 0);
      chk("t4_vec", vec_a, VEC_T2);
      chk("t4_tag", tag_a, 5'd9);
      tick();
      chk("t4_done_later", done_a, 0);

      // 5: abort coincident with the 16th beat, then a clean collection
      start_a = 1; tag_in_a = 5'd20;
      tick();
      start_a = 0;
      for (int k = 0; k < 16; k++) begin
         valid_a = 1; word_a = 16'hBB00 + 16'(k);
         abort_a = (k == 15);
         tick();
      end
      valid_a = 0; abort_a = 0;
      chk("t5_abort_busy", busy_a, 0);
      chk("t5_abort_done", done_a, 0);
      chk("t5_abort_vec", vec_a, VEC_T2);
      chk("t5_abort_tag", tag_a, 5'd9);
      start_a = 1; tag_in_a = 5'd21;
      tick();
      start_a = 0;
      for (int k = 0; k < 16; k++) begin
         valid_a = 1; word_a = 16'h2000 + 16'(k);
         tick();
      end
      valid_a = 0;
      chk("t5_done", done_a, 1);
      chk("t5_tag", tag_a, 5'd21);
      chk("t5_vec", vec_a, VEC_T5);
      tick();

      // 6: start during COLLECT and in COMMIT are both ignored
      start_a = 1; tag_in_a = 5'd17;
      tick();
      start_a = 0;
      for (int k = 0; k < 16; k++) begin
         valid_a = 1; word_a = 16'h3000 + 16'(k);
         start_a = (k == 5);
         tag_in_a = (k == 5) ? 5'd3 : 5'd17;
         tick();
      end
      valid_a = 0;
      start_a = 1; tag_in_a = 5'd3;
      chk("t6_done", done_a, 1);
      chk("t6_tag", tag_a, 5'd17);
      tick();
      start_a = 0;
      chk("t6_busy_after_commit_start", busy_a, 0);
      chk("t6_tag_hold", tag_a, 5'd17);
      tick();
      chk("t6_still_idle", busy_a, 0);

      // 3: 4x8 ascending instance with gaps in word_valid
      done_b_cnt = 0;
      start_b = 1; tag_in_b = 5'd4;
      tick();
      start_b = 0;
      for (int i = 0; i < 4; i++) begin
         valid_b = 1;
         case (i)
            0: word_b = 8'hAA;
            1: word_b = 8'hBB;
            2: word_b = 8'hCC;
            default: word_b = 8'hDD;
         endcase
         if (i == 3) chk("t3_no_partial", vec_b, '0);
         tick();
         valid_b = 0;
         tick();
         tick();
      end
      tick();
      chk("t3_vec", vec_b, 32'hDDCCBBAA);
      chk("t3_tag", tag_b, 5'd4);
      chk("t3_done_count", done_b_cnt, 1);
      chk("t3_busy", busy_b, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
